ulpi_reg_access: RTL and testbench
==================================

Name: ulpi_reg_access

Overview:
- Link-side ULPI register access engine. It drives the ULPI bus toward the PHY (TXCMD, data, STP) to perform PHY register writes and reads.
- Complements the existing logic that only samples DIR and drives PHY RST.
- Sits between the USB link controller and the PHY pins.
- Runs on the PHY's 60 MHz clock, which the top level routes to clk.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles from request accept to completion before an error response.
- TO_W, 11: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  ULPI 60 MHz clock; all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- ulpi_dir  in  1  PHY DIR; 1 = PHY owns data bus.
- ulpi_nxt  in  1  PHY NXT.
- ulpi_data_in  in  8  ULPI data bus sampled from the pad.
- ulpi_data_out  out  8  ULPI data driven by the link.
- ulpi_data_oe  out  1  pad output enable.
- ulpi_stp  out  1  ULPI STP.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = register write, 0 = register read.
- req_addr  in  6  PHY register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_error  out  1  qualifies rsp_valid; 1 = timeout.
- rsp_rdata  out  8  read data; holds until the next read completes.
- busy  out  1  state != IDLE.

Behaviour:
Reset (nrst low, async):
- state = IDLE; ulpi_data_out = 8'h00; ulpi_stp = 0; rsp_valid = 0; rsp_error = 0; rsp_rdata = 8'h00; timeout counter = 0.

Bus driving:
- ulpi_data_oe = ~ulpi_dir, combinational, so the turnaround cycle is never driven.
- ulpi_data_out and ulpi_stp are registered.
- req_ready = (state == IDLE) && !ulpi_dir.
- On accept, latch write/addr/wdata and clear the timeout counter.

States:
- IDLE: data_out = 00. On accept, go to TXCMD and set data_out = {2'b10, addr} for a write or {2'b11, addr} for a read.
- TXCMD: hold TXCMD until the PHY responds.
  - dir = 1: abort. data_out = 00, go to WAIT_BUS.
  - dir = 0, nxt = 1, write: data_out = wdata, go to WDATA.
  - dir = 0, nxt = 1, read: data_out = 00, go to RD_TURN.
- WAIT_BUS: when dir = 0, reload TXCMD from the latched request and go to TXCMD. The retry is transparent to the requester.
- WDATA: hold wdata.
  - dir = 1: abort to WAIT_BUS.
  - nxt = 1: ulpi_stp = 1, data_out = 00, go to WSTP.
- WSTP: stp is high for exactly this one cycle. Next cycle: stp = 0, rsp_valid = 1, rsp_error = 0, state = IDLE.
- RD_TURN: wait for dir = 1 (turnaround cycle, bus not driven), then go to RD_DATA.
- RD_DATA: rsp_rdata <= ulpi_data_in, go to RD_END.
- RD_END: when dir = 0, rsp_valid = 1, go to IDLE.

Timeout:
- The counter increments in every non-IDLE state.
- When it reaches TIMEOUT_CYCLES: rsp_valid = 1, rsp_error = 1, data_out = 00, stp = 0, state = IDLE. rsp_rdata is unchanged.
- Timeout has priority over any transition in the same cycle.

Latency:
- Write with NXT returned immediately: accept at cycle 0 → TXCMD on bus cycle 1 → wdata cycle 2 → STP cycle 3 → rsp_valid cycle 4.

Other rules:
- A new request can be accepted in the cycle after rsp_valid.
- nxt is ignored in IDLE, WAIT_BUS and the read states.
- Reset mid-operation: immediately return to IDLE with data_out = 00, stp = 0; no response is generated.

Optional Feature:
- ULPI_RXCMD_CAPTURE_EN defined: adds outputs rxcmd_valid (1 bit) and rxcmd (8 bits).
  - In IDLE or WAIT_BUS: when dir was 1 last cycle, dir = 1 now and nxt = 0, register ulpi_data_in into rxcmd and pulse rxcmd_valid for one cycle.
  - Both outputs reset to 0.
- Not defined: the ports and logic are absent; RX CMD bytes are ignored.

Test Plan:
- Write addr 0x0A, data 0x55, PHY model returns NXT one cycle after TXCMD → bus shows 0x8A, then 0x55, STP for 1 cycle with data 0x00; rsp_valid = 1, rsp_error = 0 exactly once.
- Read addr 0x0A, PHY asserts NXT, then DIR turnaround, then drives 0xA5 for one cycle, then drops DIR → bus shows 0xCA; oe = 0 while DIR = 1; rsp_valid with rsp_rdata = 0xA5.
- Write pending, PHY raises DIR during TXCMD before NXT, holds 3 cycles → data_out = 00, oe = 0; after DIR falls, 0x8A is reissued and the write completes normally with no error.
- Read with NXT never asserted, TIMEOUT_CYCLES = 16 → rsp_valid = 1, rsp_error = 1 exactly 16 cycles after accept; req_ready = 1 next cycle; rsp_rdata unchanged.
- nrst pulsed low mid-WDATA → outputs at reset values asynchronously, no rsp_valid; a following write completes correctly.
- With ULPI_RXCMD_CAPTURE_EN: idle link, PHY drives DIR high, then data 0x4D with NXT = 0 → rxcmd = 0x4D, rxcmd_valid pulses once per byte, and no pulse in the turnaround cycle.

Source files
------------

// File: rtl/ulpi_reg_access_if.sv
// Bus bundle between the ULPI register access engine, the PHY pins and the link controller.
// ULPI_RXCMD_CAPTURE_EN adds the rxcmd_valid/rxcmd signals.
interface ulpi_reg_access_if;
   logic       ulpi_dir;
   logic       ulpi_nxt;
   logic [7:0] ulpi_data_in;
   logic [7:0] ulpi_data_out;
   logic       ulpi_data_oe;
   logic       ulpi_stp;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_error;
   logic [7:0] rsp_rdata;
   logic       busy;
`ifdef ULPI_RXCMD_CAPTURE_EN
   logic       rxcmd_valid;
   logic [7:0] rxcmd;

   modport master (
      input  ulpi_dir, ulpi_nxt, ulpi_data_in, req_valid, req_write, req_addr, req_wdata,
      output ulpi_data_out, ulpi_data_oe, ulpi_stp, req_ready, rsp_valid, rsp_error,
             rsp_rdata, busy, rxcmd_valid, rxcmd
   );
   modport slave (
      output ulpi_dir, ulpi_nxt, ulpi_data_in, req_valid, req_write, req_addr, req_wdata,
      input  ulpi_data_out, ulpi_data_oe, ulpi_stp, req_ready, rsp_valid, rsp_error,
             rsp_rdata, busy, rxcmd_valid, rxcmd
   );
`else
   modport master (
      input  ulpi_dir, ulpi_nxt, ulpi_data_in, req_valid, req_write, req_addr, req_wdata,
      output ulpi_data_out, ulpi_data_oe, ulpi_stp, req_ready, rsp_valid, rsp_error,
             rsp_rdata, busy
   );
   modport slave (
      output ulpi_dir, ulpi_nxt, ulpi_data_in, req_valid, req_write, req_addr, req_wdata,
      input  ulpi_data_out, ulpi_data_oe, ulpi_stp, req_ready, rsp_valid, rsp_error,
             rsp_rdata, busy
   );
`endif
endinterface

// File: rtl/ulpi_reg_access.sv
// Link-side ULPI register read/write engine (TXCMD, data, STP) with request timeout.
// Optional ULPI_RXCMD_CAPTURE_EN captures RX CMD bytes while the engine is idle or waiting for the bus.
module ulpi_reg_access #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic            clk,
   input  logic            nrst,
   ulpi_reg_access_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_TXCMD, S_WAIT_BUS, S_WDATA, S_WSTP, S_RD_TURN, S_RD_DATA, S_RD_END
   } state_t;

   state_t          state_r, state_s;
   logic [7:0]      dout_r, dout_s;
   logic            stp_r, stp_s;
   logic            rsp_valid_r, rsp_valid_s;
   logic            rsp_error_r, rsp_error_s;
   logic [7:0]      rdata_r, rdata_s;
   logic [TO_W-1:0] cnt_r, cnt_s;
   logic            lat_write_r, lat_write_s;
   logic [5:0]      lat_addr_r, lat_addr_s;
   logic [7:0]      lat_wdata_r, lat_wdata_s;
   logic            ready_s;
   logic            accept_s;
   logic            to_hit_s;

   // TXCMD register command: 10aaaaaa for write, 11aaaaaa for read
   function automatic logic [7:0] txcmd_byte(input logic wr, input logic [5:0] addr);
      return {1'b1, ~wr, addr};
   endfunction

   assign ready_s  = (state_r == S_IDLE) && !bus.ulpi_dir;
   assign accept_s = bus.req_valid && ready_s;
   // Counter holds k-1 in cycle k after accept, so the error response lands TIMEOUT_CYCLES cycles after accept
   assign to_hit_s = (state_r != S_IDLE) && (cnt_r == TO_W'(TIMEOUT_CYCLES - 2));

   assign bus.ulpi_data_oe  = ~bus.ulpi_dir;
   assign bus.ulpi_data_out = dout_r;
   assign bus.ulpi_stp      = stp_r;
   assign bus.req_ready     = ready_s;
   assign bus.rsp_valid     = rsp_valid_r;
   assign bus.rsp_error     = rsp_error_r;
   assign bus.rsp_rdata     = rdata_r;
   assign bus.busy          = (state_r != S_IDLE);

   // State and output registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r     <= S_IDLE;
         dout_r      <= 8'h00;
         stp_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_error_r <= 1'b0;
         rdata_r     <= 8'h00;
         cnt_r       <= '0;
         lat_write_r <= 1'b0;
         lat_addr_r  <= 6'h00;
         lat_wdata_r <= 8'h00;
      end else begin
         state_r     <= state_s;
         dout_r      <= dout_s;
         stp_r       <= stp_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_error_r <= rsp_error_s;
         rdata_r     <= rdata_s;
         cnt_r       <= cnt_s;
         lat_write_r <= lat_write_s;
         lat_addr_r  <= lat_addr_s;
         lat_wdata_r <= lat_wdata_s;
      end
   end

   // Next-state and next-output logic; timeout overrides every transition
   always_comb begin
      state_s     = state_r;
      dout_s      = dout_r;
      stp_s       = 1'b0;
      rsp_valid_s = 1'b0;
      rsp_error_s = 1'b0;
      rdata_s     = rdata_r;
      cnt_s       = cnt_r;
      lat_write_s = lat_write_r;
      lat_addr_s  = lat_addr_r;
      lat_wdata_s = lat_wdata_r;

      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_s     = S_TXCMD;
               dout_s      = txcmd_byte(bus.req_write, bus.req_addr);
               lat_write_s = bus.req_write;
               lat_addr_s  = bus.req_addr;
               lat_wdata_s = bus.req_wdata;
               cnt_s       = '0;
            end else begin
               dout_s = 8'h00;
            end
         end
         S_TXCMD: begin
            if (bus.ulpi_dir) begin
               state_s = S_WAIT_BUS;
               dout_s  = 8'h00;
            end else if (bus.ulpi_nxt) begin
               if (lat_write_r) begin
                  state_s = S_WDATA;
                  dout_s  = lat_wdata_r;
               end else begin
                  state_s = S_RD_TURN;
                  dout_s  = 8'h00;
               end
            end else begin
               dout_s = dout_r;
            end
         end
         S_WAIT_BUS: begin
            if (!bus.ulpi_dir) begin
               state_s = S_TXCMD;
               dout_s  = txcmd_byte(lat_write_r, lat_addr_r);
            end else begin
               dout_s = 8'h00;
            end
         end
         S_WDATA: begin
            if (bus.ulpi_dir) begin
               state_s = S_WAIT_BUS;
               dout_s  = 8'h00;
            end else if (bus.ulpi_nxt) begin
               state_s = S_WSTP;
               stp_s   = 1'b1;
               dout_s  = 8'h00;
            end else begin
               dout_s = lat_wdata_r;
            end
         end
         S_WSTP: begin
            state_s     = S_IDLE;
            dout_s      = 8'h00;
            rsp_valid_s = 1'b1;
         end
         S_RD_TURN: begin
            if (bus.ulpi_dir) begin
               state_s = S_RD_DATA;
            end else begin
               state_s = S_RD_TURN;
            end
            dout_s = 8'h00;
         end
         S_RD_DATA: begin
            state_s = S_RD_END;
            rdata_s = bus.ulpi_data_in;
            dout_s  = 8'h00;
         end
         S_RD_END: begin
            if (!bus.ulpi_dir) begin
               state_s     = S_IDLE;
               rsp_valid_s = 1'b1;
            end else begin
               state_s = S_RD_END;
            end
            dout_s = 8'h00;
         end
         default: begin
            state_s = S_IDLE;
            dout_s  = 8'h00;
         end
      endcase

      if (state_r != S_IDLE) begin
         cnt_s = cnt_r + TO_W'(1);
      end else begin
         cnt_s = cnt_s;
      end

      if (to_hit_s) begin
         state_s     = S_IDLE;
         dout_s      = 8'h00;
         stp_s       = 1'b0;
         rsp_valid_s = 1'b1;
         rsp_error_s = 1'b1;
         rdata_s     = rdata_r;
      end else begin
         rsp_error_s = rsp_error_s;
      end
   end

`ifdef ULPI_RXCMD_CAPTURE_EN
   logic       dir_d_r;
   logic       rxcmd_valid_r;
   logic [7:0] rxcmd_r;

   assign bus.rxcmd_valid = rxcmd_valid_r;
   assign bus.rxcmd       = rxcmd_r;

   // RX CMD capture; the first DIR-high cycle is turnaround and is skipped via dir_d_r
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dir_d_r       <= 1'b0;
         rxcmd_valid_r <= 1'b0;
         rxcmd_r       <= 8'h00;
      end else begin
         dir_d_r <= bus.ulpi_dir;
         if (((state_r == S_IDLE) || (state_r == S_WAIT_BUS)) &&
             dir_d_r && bus.ulpi_dir && !bus.ulpi_nxt) begin
            rxcmd_valid_r <= 1'b1;
            rxcmd_r       <= bus.ulpi_data_in;
         end else begin
            rxcmd_valid_r <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed self-checking bench for ulpi_reg_access with a hand-driven PHY and requester.
module tb_ulpi_reg_access;
   logic clk;
   logic nrst;
   int   checks;
   int   failures;

   ulpi_reg_access_if u_if ();

   ulpi_reg_access #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      u_if.ulpi_dir = 1'b0; u_if.ulpi_nxt = 1'b0; u_if.ulpi_data_in = 8'h00;
      u_if.req_valid = 1'b0; u_if.req_write = 1'b0; u_if.req_addr = 6'h00; u_if.req_wdata = 8'h00;
      #12;
      checks++; if (u_if.ulpi_data_out !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=%h", u_if.ulpi_data_out, 8'h00); end
      checks++; if (u_if.ulpi_stp !== 1'b0) begin failures++; $display("FAIL rst_stp got=%b exp=0", u_if.ulpi_stp); end
      checks++; if (u_if.rsp_valid !== 1'b0 || u_if.rsp_error !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%b%b exp=00", u_if.rsp_valid, u_if.rsp_error); end
      checks++; if (u_if.rsp_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", u_if.rsp_rdata); end
      checks++; if (u_if.busy !== 1'b0 || u_if.req_ready !== 1'b1 || u_if.ulpi_data_oe !== 1'b1) begin failures++; $display("FAIL rst_ctrl busy/ready/oe got=%b%b%b exp=011", u_if.busy, u_if.req_ready, u_if.ulpi_data_oe); end
      nrst = 1'b1;
      step();
      u_if.ulpi_dir = 1'b1;
      #1;
      checks++; if (u_if.req_ready !== 1'b0 || u_if.ulpi_data_oe !== 1'b0) begin failures++; $display("FAIL idle_dir ready/oe got=%b%b exp=00", u_if.req_ready, u_if.ulpi_data_oe); end
      u_if.ulpi_dir = 1'b0;
      step();
      step();
   endtask

   task automatic test_write();
      u_if.req_valid = 1'b1; u_if.req_write = 1'b1; u_if.req_addr = 6'h0A; u_if.req_wdata = 8'h55;
      #1;
      checks++; if (u_if.req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", u_if.req_ready); end
      step();
      u_if.req_valid = 1'b0;
      checks++; if (u_if.ulpi_data_out !== 8'h8A || u_if.busy !== 1'b1) begin failures++; $display("FAIL wr_txcmd got=%h busy=%b exp=8a busy=1", u_if.ulpi_data_out, u_if.busy); end
      step();
      checks++; if (u_if.ulpi_data_out !== 8'h8A) begin failures++; $display("FAIL wr_txcmd_hold got=%h exp=8a", u_if.ulpi_data_out); end
      u_if.ulpi_nxt = 1'b1;
      step();
      checks++; if (u_if.ulpi_data_out !== 8'h55 || u_if.ulpi_stp !== 1'b0) begin failures++; $display("FAIL wr_data got=%h stp=%b exp=55 stp=0", u_if.ulpi_data_out, u_if.ulpi_stp); end
      step();
      u_if.ulpi_nxt = 1'b0;
      checks++; if (u_if.ulpi_stp !== 1'b1 || u_if.ulpi_data_out !== 8'h00 || u_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_stp got stp=%b d=%h v=%b exp stp=1 d=00 v=0", u_if.ulpi_stp, u_if.ulpi_data_out, u_if.rsp_valid); end
      step();
      checks++; if (u_if.ulpi_stp !== 1'b0 || u_if.rsp_valid !== 1'b1 || u_if.rsp_error !== 1'b0) begin failures++; $display("FAIL wr_rsp got stp=%b v=%b e=%b exp stp=0 v=1 e=0", u_if.ulpi_stp, u_if.rsp_valid, u_if.rsp_error); end
      step();
      checks++; if (u_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_once got=%b exp=0", u_if.rsp_valid); end
   endtask

   task automatic test_read();
      u_if.req_valid = 1'b1; u_if.req_write = 1'b0; u_if.req_addr = 6'h0A;
      step();
      u_if.req_valid = 1'b0;
      checks++; if (u_if.ulpi_data_out !== 8'hCA) begin failures++; $display("FAIL rd_txcmd got=%h exp=ca", u_if.ulpi_data_out); end
      u_if.ulpi_nxt = 1'b1;
      step();
      u_if.ulpi_nxt = 1'b0; u_if.ulpi_dir = 1'b1;
      #1;
      checks++; if (u_if.ulpi_data_out !== 8'h00 || u_if.ulpi_data_oe !== 1'b0) begin failures++; $display("FAIL rd_turn got d=%h oe=%b exp d=00 oe=0", u_if.ulpi_data_out, u_if.ulpi_data_oe); end
      step();
      u_if.ulpi_data_in = 8'hA5;
      checks++; if (u_if.ulpi_data_oe !== 1'b0 || u_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_data_phase got oe=%b v=%b exp oe=0 v=0", u_if.ulpi_data_oe, u_if.rsp_valid); end
      step();
      u_if.ulpi_dir = 1'b0; u_if.ulpi_data_in = 8'h00;
      checks++; if (u_if.rsp_rdata !== 8'hA5) begin failures++; $display("FAIL rd_capture got=%h exp=a5", u_if.rsp_rdata); end
      step();
      checks++; if (u_if.rsp_valid !== 1'b1 || u_if.rsp_error !== 1'b0 || u_if.rsp_rdata !== 8'hA5) begin failures++; $display("FAIL rd_rsp got v=%b e=%b d=%h exp v=1 e=0 d=a5", u_if.rsp_valid, u_if.rsp_error, u_if.rsp_rdata); end
      step();
      checks++; if (u_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_once got=%b exp=0", u_if.rsp_valid); end
   endtask

   task automatic test_abort();
      int pulses;
      pulses = 0;
      u_if.req_valid = 1'b1; u_if.req_write = 1'b1; u_if.req_addr = 6'h0A; u_if.req_wdata = 8'h55;
      step();
      u_if.req_valid = 1'b0;
      u_if.ulpi_dir = 1'b1;
      step();
      checks++; if (u_if.ulpi_data_out !== 8'h00 || u_if.ulpi_data_oe !== 1'b0) begin failures++; $display("FAIL ab_release got d=%h oe=%b exp d=00 oe=0", u_if.ulpi_data_out, u_if.ulpi_data_oe); end
      step();
      step();
      u_if.ulpi_dir = 1'b0;
      step();
      checks++; if (u_if.ulpi_data_out !== 8'h8A || u_if.ulpi_data_oe !== 1'b1) begin failures++; $display("FAIL ab_reissue got d=%h oe=%b exp d=8a oe=1", u_if.ulpi_data_out, u_if.ulpi_data_oe); end
      u_if.ulpi_nxt = 1'b1;
      step();
      checks++; if (u_if.ulpi_data_out !== 8'h55) begin failures++; $display("FAIL ab_data got=%h exp=55", u_if.ulpi_data_out); end
      step();
      u_if.ulpi_nxt = 1'b0;
      checks++; if (u_if.ulpi_stp !== 1'b1) begin failures++; $display("FAIL ab_stp got=%b exp=1", u_if.ulpi_stp); end
      step();
      checks++; if (u_if.rsp_valid !== 1'b1 || u_if.rsp_error !== 1'b0) begin failures++; $display("FAIL ab_rsp got v=%b e=%b exp v=1 e=0", u_if.rsp_valid, u_if.rsp_error); end
      step();
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      u_if.req_valid = 1'b1; u_if.req_write = 1'b0; u_if.req_addr = 6'h3F;
      step();
      u_if.req_valid = 1'b0;
      for (int i = 1; i < 16; i++) begin
         if (u_if.rsp_valid !== 1'b0) early++;
         step();
      end
      checks++; if (early !== 0) begin failures++; $display("FAIL to_early got=%0d pulses exp=0", early); end
      checks++; if (u_if.rsp_valid !== 1'b1 || u_if.rsp_error !== 1'b1) begin failures++; $display("FAIL to_rsp got v=%b e=%b exp v=1 e=1", u_if.rsp_valid, u_if.rsp_error); end
      checks++; if (u_if.rsp_rdata !== 8'hA5 || u_if.ulpi_data_out !== 8'h00) begin failures++; $display("FAIL to_hold got rdata=%h d=%h exp rdata=a5 d=00", u_if.rsp_rdata, u_if.ulpi_data_out); end
      step();
      checks++; if (u_if.req_ready !== 1'b1 || u_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL to_after got ready=%b v=%b exp ready=1 v=0", u_if.req_ready, u_if.rsp_valid); end
   endtask

   task automatic test_reset_mid_write();
      int pulses;
      pulses = 0;
      u_if.req_valid = 1'b1; u_if.req_write = 1'b1; u_if.req_addr = 6'h0A; u_if.req_wdata = 8'h55;
      step();
      u_if.req_valid = 1'b0;
      u_if.ulpi_nxt = 1'b1;
      step();
      u_if.ulpi_nxt = 1'b0;
      checks++; if (u_if.ulpi_data_out !== 8'h55) begin failures++; $display("FAIL mr_in_wdata got=%h exp=55", u_if.ulpi_data_out); end
      #2 nrst = 1'b0;
      #1;
      checks++; if (u_if.ulpi_data_out !== 8'h00 || u_if.ulpi_stp !== 1'b0 || u_if.busy !== 1'b0 || u_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL mr_async got d=%h stp=%b busy=%b v=%b exp 00 0 0 0", u_if.ulpi_data_out, u_if.ulpi_stp, u_if.busy, u_if.rsp_valid); end
      #2 nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (u_if.rsp_valid !== 1'b0) pulses++;
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL mr_no_rsp got=%0d pulses exp=0", pulses); end
      u_if.req_valid = 1'b1; u_if.req_write = 1'b1; u_if.req_addr = 6'h15; u_if.req_wdata = 8'h3C;
      step();
      u_if.req_valid = 1'b0;
      u_if.ulpi_nxt = 1'b1;
      checks++; if (u_if.ulpi_data_out !== 8'h95) begin failures++; $display("FAIL mr_txcmd got=%h exp=95", u_if.ulpi_data_out); end
      step();
      checks++; if (u_if.ulpi_data_out !== 8'h3C) begin failures++; $display("FAIL mr_data got=%h exp=3c", u_if.ulpi_data_out); end
      step();
      u_if.ulpi_nxt = 1'b0;
      checks++; if (u_if.ulpi_stp !== 1'b1 || u_if.ulpi_data_out !== 8'h00) begin failures++; $display("FAIL mr_stp got stp=%b d=%h exp stp=1 d=00", u_if.ulpi_stp, u_if.ulpi_data_out); end
      step();
      checks++; if (u_if.rsp_valid !== 1'b1 || u_if.rsp_error !== 1'b0 || u_if.ulpi_stp !== 1'b0) begin failures++; $display("FAIL mr_rsp got v=%b e=%b stp=%b exp 1 0 0", u_if.rsp_valid, u_if.rsp_error, u_if.ulpi_stp); end
      step();
   endtask

`ifdef ULPI_RXCMD_CAPTURE_EN
   task automatic test_rxcmd();
      u_if.ulpi_dir = 1'b1; u_if.ulpi_nxt = 1'b0; u_if.ulpi_data_in = 8'hFF;
      step();
      u_if.ulpi_data_in = 8'h4D;
      checks++; if (u_if.rxcmd_valid !== 1'b0) begin failures++; $display("FAIL rx_turn got=%b exp=0", u_if.rxcmd_valid); end
      step();
      u_if.ulpi_data_in = 8'h2E;
      checks++; if (u_if.rxcmd_valid !== 1'b1 || u_if.rxcmd !== 8'h4D) begin failures++; $display("FAIL rx_byte0 got v=%b d=%h exp v=1 d=4d", u_if.rxcmd_valid, u_if.rxcmd); end
      step();
      u_if.ulpi_dir = 1'b0; u_if.ulpi_data_in = 8'h00;
      checks++; if (u_if.rxcmd_valid !== 1'b1 || u_if.rxcmd !== 8'h2E) begin failures++; $display("FAIL rx_byte1 got v=%b d=%h exp v=1 d=2e", u_if.rxcmd_valid, u_if.rxcmd); end
      step();
      checks++; if (u_if.rxcmd_valid !== 1'b0 || u_if.rxcmd !== 8'h2E) begin failures++; $display("FAIL rx_end got v=%b d=%h exp v=0 d=2e", u_if.rxcmd_valid, u_if.rxcmd); end
      step();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_timeout();
      test_reset_mid_write();
`ifdef ULPI_RXCMD_CAPTURE_EN
      test_rxcmd();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
